// File: rtl/activation_pair_fetcher_pkg.sv
// Shared types and helpers for the activation pair fetcher.
package activation_pair_fetcher_pkg;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } fetch_state_e;

  localparam int unsigned STALL_CNT_WIDTH = 16;

  // Width of one stack word: a full layer of activations
  function automatic int unsigned stack_width(input int unsigned neuron_num,
                                              input int unsigned act_width);
    return neuron_num * act_width;
  endfunction

endpackage

// File: rtl/activation_pair_fetcher.sv
// Walks the activation stack from layer L-1 down to 0, fetching the
// (addr, addr+1) activation pair for each layer and handing it to a consumer.
// Optional build macro: ACT_FETCH_STALL_CNT_EN adds a saturating stall_count
// output counting cycles a pair waited on the consumer.
module activation_pair_fetcher
  import activation_pair_fetcher_pkg::*;
#(
  parameter int unsigned NEURON_NUM       = 6,
  parameter int unsigned ACTIVATION_WIDTH = 8,
  parameter int unsigned STACK_ADDR_WIDTH = 10,
  localparam int unsigned STACK_WIDTH     = stack_width(NEURON_NUM, ACTIVATION_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [STACK_ADDR_WIDTH-1:0] start_layers,
  input  logic                        start_valid,
  output logic                        start_ready,
  output logic [STACK_ADDR_WIDTH-1:0] stack_addr,
  output logic                        stack_addr_valid,
  input  logic                        stack_addr_ready,
  input  logic [STACK_WIDTH-1:0]      stack_lower_data,
  input  logic [STACK_WIDTH-1:0]      stack_higher_data,
  input  logic                        stack_lower_valid,
  input  logic                        stack_higher_valid,
  output logic                        stack_lower_ready,
  output logic                        stack_higher_ready,
  output logic [STACK_WIDTH-1:0]      pair_lower,
  output logic [STACK_WIDTH-1:0]      pair_higher,
  output logic [STACK_ADDR_WIDTH-1:0] pair_layer,
  output logic                        pair_last,
  output logic                        pair_valid,
  input  logic                        pair_ready,
`ifdef ACT_FETCH_STALL_CNT_EN
  output logic [STALL_CNT_WIDTH-1:0]  stall_count,
`endif
  output logic                        busy
);

  localparam int unsigned AW = STACK_ADDR_WIDTH;

  fetch_state_e  state_q, state_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          issue_q;

  // Read data timing is fixed (one cycle after address acceptance), so the
  // stack valid strobes carry no information here.
  logic unused_stack_valids;
  assign unused_stack_valids = &{1'b0, stack_lower_valid, stack_higher_valid};

  // Next-state and address sequencing
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid && (start_layers != '0)) begin
          state_n = ST_ISSUE;
          addr_n  = start_layers - AW'(1);
        end
      end
      ST_ISSUE: begin
        if (stack_addr_ready) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (pair_ready) begin
          if (addr_q == '0) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_ISSUE;
            addr_n  = addr_q - AW'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and current-layer address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
    end
  end

  // Handshake and status flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready <= 1'b1;
      issue_q     <= 1'b0;
      pair_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_ready <= (state_n == ST_IDLE);
      issue_q     <= (state_n == ST_ISSUE);
      pair_valid  <= (state_n == ST_HOLD);
      busy        <= (state_n != ST_IDLE);
    end
  end

  assign stack_addr         = addr_q;
  assign stack_addr_valid   = issue_q;
  assign stack_lower_ready  = issue_q;
  assign stack_higher_ready = issue_q;

  // Capture the pair on the cycle the stack returns it; held through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_lower  <= '0;
      pair_higher <= '0;
      pair_layer  <= '0;
      pair_last   <= 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      pair_lower  <= stack_lower_data;
      pair_higher <= stack_higher_data;
      pair_layer  <= addr_q;
      pair_last   <= (addr_q == '0);
    end
  end

`ifdef ACT_FETCH_STALL_CNT_EN
  // Saturating count of cycles a presented pair waited on the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if ((state_q == ST_IDLE) && start_valid) begin
      stall_count <= '0;
    end else if ((state_q == ST_HOLD) && !pair_ready && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end
`endif

endmodule
